memory_edit_sequencer: RTL and testbench

//   Synchronous replacement controller for the lab1 16x8 RAM datapath.

---
 rtl/memory_edit_sequencer_pkg.sv | 19 +
 rtl/memory_edit_sequencer_if.sv | 25 ++
 rtl/memory_edit_sequencer_debounce.sv | 43 ++++
 rtl/memory_edit_sequencer.sv | 98 +++++++++
 tb/tb_memory_edit_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_edit_sequencer_pkg.sv
// Shared types and constants for the lab1 RAM edit sequencer.
// Key indices double as pending-register bit positions.
package lab1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

    localparam int KEY_ADDR_INC = 3;
    localparam int KEY_ADDR_DEC = 2;
    localparam int KEY_DATA_INC = 1;
    localparam int KEY_DATA_DEC = 0;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

endpackage

// File: rtl/memory_edit_sequencer_if.sv
// RAM port bundle: the sequencer drives address/data/enable,
// the memory returns registered read data.
interface memory_edit_sequencer_if;
    import lab1_pkg::*;

    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] din;
    logic              we;
    logic [DATA_W-1:0] dout;

    modport master (
        output a,
        output din,
        output we,
        input  dout
    );

    modport slave (
        input  a,
        input  din,
        input  we,
        output dout
    );

endinterface

// File: rtl/memory_edit_sequencer_debounce.sv
// Per-key synchronizer and debouncer; emits a one-cycle pulse
// when the accepted level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            // Any sample matching the accepted level restarts the stability window.
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                count <= '0;
                level <= sync_2;
                press <= ~sync_2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_edit_sequencer.sv
// Turns debounced key presses into address steps or read-modify-write
// data steps on the lab1 16x8 RAM, one operation at a time.
module memory_edit_sequencer
    import lab1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              KEY,
    memory_edit_sequencer_if.master ram,
    output logic                    busy
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [3:0]        key_level;
    logic [3:0]        press;
    logic [3:0]        pending;
    logic [3:0]        launch;
    logic [ADDR_W-1:0] a_next;
    logic [DATA_W-1:0] din_next;
    logic              we_next;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .key_n (KEY[i]),
            .level (key_level[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            ram.a   <= '0;
            ram.din <= '0;
            ram.we  <= 1'b0;
        end else begin
            state   <= next_state;
            // A fresh press outranks the launch clear of the same bit.
            pending <= (pending & ~launch) | press;
            ram.a   <= a_next;
            ram.din <= din_next;
            ram.we  <= we_next;
        end
    end

    always_comb begin
        next_state = state;
        launch     = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    priority case (1'b1)
                        pending[KEY_ADDR_INC]: launch[KEY_ADDR_INC] = 1'b1;
                        pending[KEY_ADDR_DEC]: launch[KEY_ADDR_DEC] = 1'b1;
                        pending[KEY_DATA_INC]: launch[KEY_DATA_INC] = 1'b1;
                        default:               launch[KEY_DATA_DEC] = 1'b1;
                    endcase
                    if (launch[KEY_ADDR_INC] || launch[KEY_ADDR_DEC]) begin
                        next_state = SETTLE;
                    end else begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE:   next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        a_next   = ram.a;
        din_next = ram.din;
        we_next  = 1'b0;
        if (launch[KEY_ADDR_INC]) begin
            a_next = ram.a + 1'b1;
        end else if (launch[KEY_ADDR_DEC]) begin
            a_next = ram.a - 1'b1;
        end else if (launch[KEY_DATA_INC]) begin
            din_next = ram.dout + 1'b1;
            we_next  = 1'b1;
        end else if (launch[KEY_DATA_DEC]) begin
            din_next = ram.dout - 1'b1;
            we_next  = 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_memory_edit_sequencer.sv
// Directed bench for memory_edit_sequencer with an operation-level
// reference model and a zero-initialised lab1 RAM.
module tb_memory_edit_sequencer;

    typedef enum int {OP_AI, OP_AD, OP_DI, OP_DD} op_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic       busy;

    int total = 0;
    int bad   = 0;

    memory_edit_sequencer_if ram_bus ();

    memory_edit_sequencer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .ram   (ram_bus.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // lab1 RAM: synchronous write, registered read
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_bus.dout = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_bus.we) mem[ram_bus.a] <= ram_bus.din;
        ram_bus.dout <= mem[ram_bus.a];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Operation-level model
    op_t        exp_ops [$];
    logic [3:0] model_a = 4'h0;
    logic [7:0] model_mem [16];
    logic [3:0] prev_a = 4'h0;
    logic       prev_we = 1'b0;
    int         we_pulses = 0;

    initial for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    always @(negedge clk) begin
        op_t        op;
        logic [7:0] exp_d;
        logic [3:0] exp_a;
        if (reset) begin
            exp_ops.delete();
            model_a = 4'h0;
            prev_a  = 4'h0;
            prev_we = 1'b0;
        end else begin
            if (ram_bus.we) begin
                we_pulses++;
                check("we_single_cycle", prev_we, 0);
                if (exp_ops.size() == 0) begin
                    check("unexpected_write", exp_ops.size(), 1);
                end else begin
                    op = exp_ops.pop_front();
                    check("write_kind", int'(op == OP_DI || op == OP_DD), 1);
                    exp_d = (op == OP_DI) ? model_mem[model_a] + 8'd1
                                          : model_mem[model_a] - 8'd1;
                    check("write_addr", ram_bus.a, model_a);
                    check("write_din", ram_bus.din, exp_d);
                    check("write_busy", busy, 1);
                    model_mem[model_a] = exp_d;
                end
            end
            if (ram_bus.a != prev_a) begin
                if (exp_ops.size() == 0) begin
                    check("unexpected_addr_step", exp_ops.size(), 1);
                    model_a = ram_bus.a;
                end else begin
                    op = exp_ops.pop_front();
                    check("addr_kind", int'(op == OP_AI || op == OP_AD), 1);
                    exp_a = (op == OP_AD) ? model_a - 4'd1 : model_a + 4'd1;
                    check("addr_value", ram_bus.a, exp_a);
                    check("addr_busy", busy, 1);
                    model_a = exp_a;
                end
            end
            prev_a  = ram_bus.a;
            prev_we = ram_bus.we;
        end
    end

    task automatic press(input int k);
        @(negedge clk) KEY[k] = 1'b0;
        repeat (20) @(negedge clk);
        KEY[k] = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic step(input int k, input op_t op);
        exp_ops.push_back(op);
        press(k);
    endtask

    initial begin
        int  w0;
        bit  seen;
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w0;
        bit  seen;
        KEY   = 4'hF;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a", ram_bus.a, 0);
        check("rst_din", ram_bus.din, 0);
        check("rst_we", ram_bus.we, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single press, hold, release
        step(3, OP_AI);
        check("t1_a", ram_bus.a, 4'h1);
        check("t1_dout", ram_bus.dout, 8'h00);
        check("t1_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("t1_release_a", ram_bus.a, 4'h1);
        check("t1_queue", exp_ops.size(), 0);

        // 2: wrap down and wrap up
        step(2, OP_AD);
        check("t2_a0", ram_bus.a, 4'h0);
        step(2, OP_AD);
        check("t2_aF", ram_bus.a, 4'hF);
        step(3, OP_AI);
        check("t2_back0", ram_bus.a, 4'h0);
        for (int i = 0; i < 16; i++) step(3, OP_AI);
        check("t2_wrap", ram_bus.a, 4'h0);

        // 3: read-modify-write at a=5
        for (int i = 0; i < 5; i++) step(3, OP_AI);
        check("t3_a", ram_bus.a, 4'h5);
        w0 = we_pulses;
        step(1, OP_DI);
        check("t3_mem_01", mem[5], 8'h01);
        check("t3_one_we", we_pulses - w0, 1);
        step(0, OP_DD);
        step(0, OP_DD);
        check("t3_mem_FF", mem[5], 8'hFF);
        step(1, OP_DI);
        check("t3_mem_00", mem[5], 8'h00);

        // 4: bouncing key gives exactly one write
        w0 = we_pulses;
        exp_ops.push_back(OP_DI);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk) KEY[1] = ~KEY[1];
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        KEY[1] = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_one_we", we_pulses - w0, 1);
        check("t4_mem", mem[5], 8'h01);

        // 5: simultaneous presses at a=2
        for (int i = 0; i < 3; i++) step(2, OP_AD);
        check("t5_a2", ram_bus.a, 4'h2);
        exp_ops.push_back(OP_AI);
        exp_ops.push_back(OP_DI);
        @(negedge clk) KEY = 4'b0101;
        repeat (20) @(negedge clk);
        KEY = 4'hF;
        repeat (20) @(negedge clk);
        check("t5_a3", ram_bus.a, 4'h3);
        check("t5_mem3", mem[3], 8'h01);
        check("t5_mem2", mem[2], 8'h00);
        check("t5_queue", exp_ops.size(), 0);

        // 6: reset lands on the write cycle
        w0 = we_pulses;
        exp_ops.push_back(OP_DI);
        @(negedge clk) KEY[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ram_bus.we) seen = 1'b1;
        end
        check("t6_we_seen", seen, 1);
        reset = 1'b1;
        KEY   = 4'hF;
        #1;
        check("t6_we", ram_bus.we, 0);
        check("t6_a", ram_bus.a, 0);
        check("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t6_mem3", mem[3], 8'h01);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_no_op_a", ram_bus.a, 0);
        check("t6_no_write", we_pulses - w0, 0);
        check("t6_queue", exp_ops.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
